// File: rtl/kbd_pkg.sv
// kbd_pkg: shared frame geometry and idle values for the keyboard SPI link
package kbd_pkg;
  localparam int FRAME_BITS = 48;
  localparam int ROWS = 8;
  localparam int COLS = 5;
  localparam logic [ROWS*COLS-1:0] KEYS_RELEASED = 40'hFF_FFFF_FFFF;
  localparam logic [7:0] JOY_IDLE = 8'h00;
  typedef logic [ROWS*COLS-1:0] matrix_t;
endpackage

// File: rtl/kbd_spi_sync.sv
// kbd_spi_sync: 2-flop synchroniser with rise/fall detect on the synchronised level
module kbd_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK_14MHZ,
  input  logic CPU_RESET,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, prev;
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) {s1, q, prev} <= {3{RST_VAL}};
    else {s1, q, prev} <= {d, s1, q};
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/kbd_spi_receiver.sv
// kbd_spi_receiver: SPI slave that latches 48-bit key-matrix/joystick frames and serves port #FE
module kbd_spi_receiver
  import kbd_pkg::*;
#(
  parameter int WDT_BITS = 20
) (
  input  logic       CLK_14MHZ,
  input  logic       CPU_RESET,
  input  logic       KBD_CLK,
  input  logic       KBD_CS,
  input  logic       KBD_DI,
  input  logic [7:0] A_HI,
  output logic [4:0] KD,
  output logic [7:0] JOY,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic       LINK_OK
);
  logic clk_s, clk_rise, clk_fall, cs_s, cs_rise, cs_fall, unused_clk;
  logic hit, commit, armed;
  logic [1:0] di_q, rdy;
  logic [FRAME_BITS-1:0] shreg;
  logic [5:0] cnt;
  logic [WDT_BITS-1:0] wdt;
  matrix_t matrix;
  kbd_spi_sync #(.RST_VAL(1'b0)) u_clk (
    .CLK_14MHZ(CLK_14MHZ), .CPU_RESET(CPU_RESET), .d(KBD_CLK),
    .q(clk_s), .rise(clk_rise), .fall(clk_fall)
  );
  kbd_spi_sync #(.RST_VAL(1'b1)) u_cs (
    .CLK_14MHZ(CLK_14MHZ), .CPU_RESET(CPU_RESET), .d(KBD_CS),
    .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  assign unused_clk = clk_s & clk_fall;
  // The synchroniser's reset value of CS is not a real observation, so edges are
  // ignored until CS has been seen high through a filled synchroniser.
  assign hit = armed & cs_rise;
  assign commit = hit & (cnt == 6'(FRAME_BITS));
  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET)
    if (!CPU_RESET) begin
      di_q      <= '0;
      rdy       <= '0;
      armed     <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      matrix    <= KEYS_RELEASED;
      JOY       <= JOY_IDLE;
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
      LINK_OK   <= 1'b0;
      wdt       <= '0;
    end else begin
      di_q      <= {di_q[0], KBD_DI};
      rdy       <= {rdy[0], 1'b1};
      armed     <= armed | (rdy[1] & cs_s);
      FRAME_OK  <= commit;
      FRAME_ERR <= hit & ~commit;
      if (armed & cs_fall) cnt <= '0;
      else if (armed & ~cs_s & clk_rise) begin
        shreg <= {shreg[FRAME_BITS-2:0], di_q[1]};
        cnt   <= cnt + {5'd0, ~&cnt};
      end
      if (commit) begin
        matrix  <= shreg[FRAME_BITS-1:8];
        JOY     <= shreg[7:0];
        LINK_OK <= 1'b1;
        wdt     <= '0;
      end else if (&wdt) begin
        matrix  <= KEYS_RELEASED;
        JOY     <= JOY_IDLE;
        LINK_OK <= 1'b0;
      end else wdt <= wdt + WDT_BITS'(1);
    end
  always_comb begin
    KD = '1;
    for (int r = 0; r < ROWS; r++) KD &= matrix[r*COLS +: COLS] | {COLS{A_HI[r]}};
  end
endmodule
